// File: rtl/ncl_pkg.sv
// rtl/ncl_pkg.sv - shared state enum and dual-rail NULL/encode/decode helpers for the NCL phase sequencer
package ncl_pkg;

    localparam int MAX_WIDTH = 64;

    typedef logic [MAX_WIDTH-1:0]   sr_word_t;
    typedef logic [2*MAX_WIDTH-1:0] dr_word_t;

    typedef enum logic [2:0] {
        IDLE,
        NULL_HI,
        NULL_LO,
        DATA,
        CAPTURE,
        ERR
    } state_t;

    // Rails below 2*width take the NULL level; bits above it stay 0 and are cut off by callers.
    function automatic dr_word_t null_rails(input int width, input logic level);
        dr_word_t r;
        r = '0;
        for (int i = 0; i < 2*MAX_WIDTH; i++) begin
            r[i] = (i < 2*width) ? level : 1'b0;
        end
        return r;
    endfunction

    function automatic dr_word_t null_hi_rails(input int width);
        return null_rails(width, 1'b1);
    endfunction

    function automatic dr_word_t null_lo_rails(input int width);
        return null_rails(width, 1'b0);
    endfunction

    function automatic dr_word_t encode(input sr_word_t v);
        dr_word_t r;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            r[2*i+1] = v[i];
            r[2*i]   = ~v[i];
        end
        return r;
    endfunction

    function automatic sr_word_t decode(input dr_word_t d);
        sr_word_t v;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            v[i] = d[2*i+1];
        end
        return v;
    endfunction

endpackage

// File: rtl/ncl_completion.sv
// rtl/ncl_completion.sv - combinational hi-NULL, lo-NULL and DATA completion detectors on a dual-rail bus
import ncl_pkg::*;

module ncl_completion #(
    parameter int WIDTH = 24
) (
    input  logic [2*WIDTH-1:0] rails,
    output logic               hi_null,
    output logic               lo_null,
    output logic               data_rdy
);
    logic [WIDTH-1:0] pair_valid;

    always_comb begin
        pair_valid = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pair_valid[i] = rails[2*i+1] ^ rails[2*i];
        end
    end

    assign hi_null  = &rails;
    assign lo_null  = ~|rails;
    assign data_rdy = &pair_valid;

endmodule

// File: rtl/ncl_phase_sequencer.sv
// rtl/ncl_phase_sequencer.sv - registered NULL_HI/NULL_LO/DATA phase FSM with start/done handshake
// Optional per-phase watchdog enabled by defining NCL_PHASE_TIMEOUT_EN.
import ncl_pkg::*;

module ncl_phase_sequencer #(
    parameter int WIDTH   = 24,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    output logic [2*WIDTH-1:0] rails_out,
    input  logic [2*WIDTH-1:0] rails_in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               error
);
    localparam logic [2*WIDTH-1:0] RAILS_HI = (2*WIDTH)'(null_hi_rails(WIDTH));
    localparam logic [2*WIDTH-1:0] RAILS_LO = (2*WIDTH)'(null_lo_rails(WIDTH));

    state_t             state;
    state_t             phase_next;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] data_rails;
    logic [2*WIDTH-1:0] phase_rails;
    logic               phase_flag;
    logic               hi_null;
    logic               lo_null;
    logic               data_rdy;
    // {hi_null, lo_null, data_rdy}; rails_in is asynchronous to clk
    logic [2:0]         sync_s1;
    logic [2:0]         sync_s2;

`ifdef NCL_PHASE_TIMEOUT_EN
    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    logic [CNT_W-1:0] phase_cnt;
    logic             error_q;
    assign error = error_q;
`else
    // Without the watchdog ERR is unreachable; TIMEOUT is inert and error is constant 0.
    assign error = (TIMEOUT < 0);
`endif

    ncl_completion #(.WIDTH(WIDTH)) u_completion (
        .rails    (rails_in),
        .hi_null  (hi_null),
        .lo_null  (lo_null),
        .data_rdy (data_rdy)
    );

    assign data_rails = (2*WIDTH)'(encode(sr_word_t'(operand)));

    always_comb begin
        phase_flag  = 1'b0;
        phase_next  = IDLE;
        phase_rails = RAILS_HI;
        case (state)
            NULL_HI: begin
                phase_flag  = sync_s2[2];
                phase_next  = NULL_LO;
                phase_rails = RAILS_LO;
            end
            NULL_LO: begin
                phase_flag  = sync_s2[1];
                phase_next  = DATA;
                phase_rails = data_rails;
            end
            DATA: begin
                phase_flag  = sync_s2[0];
                phase_next  = CAPTURE;
                phase_rails = RAILS_HI;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rails_out <= RAILS_HI;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            operand   <= '0;
            sync_s1   <= '0;
            sync_s2   <= '0;
`ifdef NCL_PHASE_TIMEOUT_EN
            phase_cnt <= '0;
            error_q   <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            sync_s1 <= {hi_null, lo_null, data_rdy};
            sync_s2 <= sync_s1;
            case (state)
                IDLE, ERR: begin
                    rails_out <= RAILS_HI;
                    if (start) begin
                        operand <= data_in;
                        busy    <= 1'b1;
                        state   <= NULL_HI;
                        sync_s1 <= '0;
                        sync_s2 <= '0;
`ifdef NCL_PHASE_TIMEOUT_EN
                        phase_cnt <= '0;
                        error_q   <= 1'b0;
`endif
                    end
                end
                NULL_HI, NULL_LO, DATA: begin
                    // A flag that lands with the timeout still completes the phase.
                    if (phase_flag) begin
                        state     <= phase_next;
                        rails_out <= phase_rails;
                        sync_s1   <= '0;
                        sync_s2   <= '0;
`ifdef NCL_PHASE_TIMEOUT_EN
                        phase_cnt <= '0;
`endif
                        if (phase_next == CAPTURE) begin
                            result <= WIDTH'(decode(dr_word_t'(rails_in)));
                            done   <= 1'b1;
                            busy   <= 1'b0;
                        end
                    end
`ifdef NCL_PHASE_TIMEOUT_EN
                    else if (phase_cnt == CNT_LIMIT) begin
                        state     <= ERR;
                        rails_out <= RAILS_HI;
                        busy      <= 1'b0;
                        error_q   <= 1'b1;
                        sync_s1   <= '0;
                        sync_s2   <= '0;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
`endif
                end
                CAPTURE: begin
                    state     <= IDLE;
                    rails_out <= RAILS_HI;
                    sync_s1   <= '0;
                    sync_s2   <= '0;
                end
                default: begin
                    state     <= IDLE;
                    rails_out <= RAILS_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ncl_phase_sequencer.sv
// tb/tb_ncl_phase_sequencer.sv - self-checking bench with incrementer datapath model and result scoreboard
module tb_ncl_phase_sequencer;
    localparam int WIDTH = 24;
`ifdef NCL_PHASE_TIMEOUT_EN
    localparam int TIMEOUT = 16;
`else
    localparam int TIMEOUT = 1023;
`endif
    localparam int RW = 2*WIDTH;
    localparam logic [RW-1:0] ONES = '1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [RW-1:0]    rails_out;
    logic [RW-1:0]    rails_in;
    logic [RW-1:0]    base_rails;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             error;

    // 0: zero-delay incrementer, 1: incrementer behind a 6-stage delay line, 2: stuck at high-NULL
    int               mode = 0;
    logic             glitch = 1'b0;
    logic [RW-1:0]    pipe [6];

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] exp_q [$];

    typedef struct {
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] exp;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    ncl_phase_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .data_in   (data_in),
        .rails_out (rails_out),
        .rails_in  (rails_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .error     (error)
    );

    function automatic logic [RW-1:0] enc(input logic [WIDTH-1:0] v);
        logic [RW-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[2*i+1] = v[i];
            r[2*i]   = ~v[i];
        end
        return r;
    endfunction

    function automatic logic [RW-1:0] inc_model(input logic [RW-1:0] r);
        logic [WIDTH-1:0] v;
        v = '0;
        if (r == ONES) return ONES;
        if (r == '0) return '0;
        for (int i = 0; i < WIDTH; i++) v[i] = r[2*i+1];
        return enc(v + 1'b1);
    endfunction

    always @(posedge clk) begin
        pipe[0] <= rails_out;
        for (int i = 1; i < 6; i++) pipe[i] <= pipe[i-1];
    end

    always_comb begin
        base_rails = ONES;
        case (mode)
            0: base_rails = inc_model(rails_out);
            1: base_rails = inc_model(pipe[5]);
            default: base_rails = ONES;
        endcase
        rails_in = glitch ? (base_rails | RW'(3)) : base_rails;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else check("result", 64'(result), 64'(exp_q.pop_front()));
        end
    end

    // Cycle k is the k-th falling edge after the accepting rising edge.
    task automatic run_op(input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] exp, input bit do_glitch,
                          output int done_cyc, output int busy_cnt, output int lo_cyc, output int data_cyc);
        done_cyc = 0; busy_cnt = 0; lo_cyc = 0; data_cyc = 0;
        @(negedge clk);
        start   = 1'b1;
        data_in = din;
        exp_q.push_back(exp);
        @(posedge clk);
        for (int k = 1; k <= 300 && done_cyc == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (lo_cyc == 0 && rails_out == '0) lo_cyc = k;
            if (data_cyc == 0 && rails_out != ONES && rails_out != '0) begin
                data_cyc = k;
                glitch   = do_glitch;
            end else begin
                glitch = 1'b0;
            end
            if (done) done_cyc = k;
        end
        glitch = 1'b0;
        if (done_cyc == 0) check("op_done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int dc, bc, lc, ac, first_done, second_done, ec;

        vecs[0] = '{24'h000005, 24'h000006};
        vecs[1] = '{24'hFFFFFF, 24'h000000};
        vecs[2] = '{24'h000010, 24'h000011};
        vecs[3] = '{24'h7FFFFF, 24'h800000};
        vecs[4] = '{24'hA5A5A5, 24'hA5A5A6};
        vecs[5] = '{24'h00FFFF, 24'h010000};

        repeat (3) @(negedge clk);
        check("reset_rails", 64'(rails_out), 64'(ONES));
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_error", 64'(error), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].din, vecs[i].exp, 1'b0, dc, bc, lc, ac);
            check("zd_done_cycle", 64'(dc), 64'd10);
            check("zd_busy_cycles", 64'(bc), 64'd9);
            check("zd_null_lo_cycle", 64'(lc), 64'd4);
            check("zd_data_cycle", 64'(ac), 64'd7);
        end

        mode = 1;
        repeat (8) @(negedge clk);
        run_op(24'hFFFFFF, 24'h000000, 1'b0, dc, bc, lc, ac);
        check("dly_null_hi_dwell", 64'(lc - 1), 64'd3);
        check("dly_null_lo_dwell", 64'(ac - lc), 64'd9);
        check("dly_data_dwell", 64'(dc - ac), 64'd9);
        mode = 0;
        repeat (8) @(negedge clk);

        run_op(24'h123456, 24'h123457, 1'b1, dc, bc, lc, ac);
        check("glitch_data_dwell", 64'(dc - ac), 64'd4);
        check("glitch_done_cycle", 64'(dc), 64'd11);

        first_done = 0; second_done = 0;
        exp_q.push_back(24'h000011);
        exp_q.push_back(24'h000011);
        @(negedge clk);
        start   = 1'b1;
        data_in = 24'h000010;
        for (int k = 1; k <= 100 && second_done == 0; k++) begin
            @(negedge clk);
            data_in = ((k >= 3 && k <= 7) || k >= 14) ? 24'h000777 : 24'h000010;
            if (done) begin
                if (first_done == 0) first_done = k;
                else second_done = k;
            end
        end
        start = 1'b0;
        check("b2b_first_done", 64'(first_done), 64'd10);
        check("b2b_gap", 64'(second_done - first_done), 64'd11);
        repeat (3) @(negedge clk);
        check("b2b_idle_after", 64'(busy), 64'd0);

        @(negedge clk);
        start   = 1'b1;
        data_in = 24'h000005;
        exp_q.push_back(24'h000006);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && (rails_out == ONES || rails_out == '0); k++) @(negedge clk);
        check("rst_reached_data", 64'(rails_out != ONES && rails_out != '0), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_rails", 64'(rails_out), 64'(ONES));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("rst_still_idle", 64'(busy), 64'd0);
        run_op(24'h000005, 24'h000006, 1'b0, dc, bc, lc, ac);
        check("rst_recover_done_cycle", 64'(dc), 64'd10);

`ifdef NCL_PHASE_TIMEOUT_EN
        mode = 2;
        lc = 0; ec = 0;
        @(negedge clk);
        start   = 1'b1;
        data_in = 24'h0000AA;
        @(posedge clk);
        for (int k = 1; k <= 100 && ec == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (lc == 0 && rails_out == '0) lc = k;
            if (error) begin
                ec = k;
                check("to_busy", 64'(busy), 64'd0);
                check("to_rails", 64'(rails_out), 64'(ONES));
            end
        end
        check("to_error_delay", 64'(ec - lc), 64'd17);
        repeat (5) @(negedge clk);
        check("to_error_sticky", 64'(error), 64'd1);
        mode = 0;
        run_op(24'h0000AA, 24'h0000AB, 1'b0, dc, bc, lc, ac);
        check("to_recover_done_cycle", 64'(dc), 64'd10);
        check("to_error_cleared", 64'(error), 64'd0);
`else
        check("error_tied_low", 64'(error), 64'd0);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
